fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the write port of the team's asynchronous FIFO (winc/wdata/wfull) among NREQ requesters.
- Sits entirely in the write-clock domain, directly in front of the FIFO write side.
- Grants are burst-locked: a winner owns the port until it sends a last beat or MAX_BURST beats are accepted.
- Honours wfull back-pressure beat by beat.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-locked round-robin arbiter for the async FIFO write port
//
// Shares one FIFO write side (winc/wdata/wfull) among NREQ requesters in the
// wclk domain. A winner keeps the port until it sends a last beat or
// MAX_BURST beats are accepted; one IDLE cycle separates consecutive bursts.
//
// Ports:
//   wclk       write-domain clock
//   wrstn      asynchronous active-low reset
//   req_valid  per-requester beat valid
//   req_last   per-requester last beat of packet
//   req_data   requester i data at [i*WIDTH +: WIDTH]
//   req_ready  per-requester beat accept
//   wfull      FIFO full flag
//   winc       FIFO write strobe
//   wdata      FIFO write data
//   grant_id   current owner index (meaningful while busy)
//   busy       high while a burst owns the port

module fifo_wr_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int GW        = $clog2(NREQ)
) (
    input  logic                    wclk,
    input  logic                    wrstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [WIDTH-1:0]        wdata,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand_g;
    int              cand;
    logic            sel_valid;
    logic            sel_last;

    // Round-robin pick: scan offsets from high to low so the smallest offset
    // from rr_ptr (the first valid requester at or after it) wins last.
    always_comb begin
        pick   = rr_ptr_q;
        cand   = 0;
        cand_g = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand   = (int'(rr_ptr_q) + i) % NREQ;
            cand_g = GW'(cand);
            if (req_valid[cand_g]) begin
                pick = cand_g;
            end
        end
    end

    // Owner's data/valid/last, selected by constant-index compare.
    always_comb begin
        wdata     = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                wdata     = req_data[i*WIDTH +: WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        busy       = 1'b0;
        winc       = 1'b0;
        req_ready  = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                busy = 1'b1;
                // Ready is withheld while full, so no beat can slip through.
                if (!wfull) begin
                    req_ready = NREQ'(1) << grant_q;
                end
                winc = sel_valid & ~wfull;
                if (winc) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (sel_last || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int GW        = 2;

    logic                  wclk = 1'b0;
    logic                  wrstn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [WIDTH-1:0]      wdata;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .wrstn     (wrstn),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side stimulus state
    logic            drv_rst_n;
    logic            drv_full;
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] drop;
    int              plen [NREQ];
    int              bidx [NREQ];
    logic [7:0]      base [NREQ];

    // Observed outputs
    logic            o_winc, o_busy;
    logic [7:0]      o_wdata;
    logic [GW-1:0]   o_grant;
    logic [NREQ-1:0] o_ready;

    // Reference model: owner (-1 = no grant), rotation pointer, beats taken
    int              m_owner, m_rr, m_taken;
    logic            e_busy, e_winc;
    logic [7:0]      e_wdata;
    int              e_grant;
    logic [NREQ-1:0] e_ready;

    task automatic step();
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] l;
        logic            picked;
        @(posedge wclk);
        #1;
        v = en & ~drop;
        for (int i = 0; i < NREQ; i++) begin
            l[i] = (plen[i] != 0) && (bidx[i] == plen[i] - 1);
            req_data[i*WIDTH +: WIDTH] = base[i] + 8'(bidx[i]);
        end
        req_valid = v;
        req_last  = l;
        wfull     = drv_full;
        wrstn     = drv_rst_n;
        #1;
        o_winc  = winc;
        o_busy  = busy;
        o_wdata = wdata;
        o_grant = grant_id;
        o_ready = req_ready;

        if (!drv_rst_n) begin
            m_owner = -1;
            m_rr    = 0;
        end
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? m_owner : 0;
        e_ready = '0;
        e_winc  = 1'b0;
        e_wdata = '0;
        if (e_busy) begin
            if (!drv_full) e_ready[m_owner] = 1'b1;
            e_winc  = v[m_owner] && !drv_full;
            e_wdata = base[m_owner] + 8'(bidx[m_owner]);
            if (e_winc) begin
                m_taken++;
                if (l[m_owner] || m_taken == MAX_BURST) begin
                    m_rr    = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end else if (drv_rst_n) begin
            picked = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!picked && v[(m_rr + k) % NREQ]) begin
                    m_owner = (m_rr + k) % NREQ;
                    m_taken = 0;
                    picked  = 1'b1;
                end
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && o_ready[i]) begin
                if (l[i]) begin
                    en[i]   = 1'b0;
                    bidx[i] = 0;
                end else begin
                    bidx[i]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        drv_rst_n = 1'b0;
        drv_full  = 1'b0;
        en        = '0;
        drop      = '0;
        for (int i = 0; i < NREQ; i++) begin
            plen[i] = 0;
            bidx[i] = 0;
            base[i] = 8'(i * 16);
        end
        step();
        step();
        drv_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drv_rst_n = 1'b0;
        drv_full  = 1'b0;
        en        = '1;
        drop      = '0;
        for (int i = 0; i < NREQ; i++) begin
            plen[i] = 0;
            bidx[i] = 0;
            base[i] = 8'(i * 16);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (o_winc !== 1'b0) begin n_errors++; $display("FAIL reset_winc got=%0b exp=0", o_winc); end
            n_checks++;
            if (o_ready !== 4'b0) begin n_errors++; $display("FAIL reset_ready got=%b exp=0000", o_ready); end
            n_checks++;
            if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
        end
        drv_rst_n = 1'b1;
        step();
        n_checks++;
        if (o_busy !== 1'b0) begin n_errors++; $display("FAIL release_idle got=%0b exp=0", o_busy); end
        step();
        n_checks++;
        if (o_busy !== 1'b1 || o_grant !== 2'd0) begin
            n_errors++; $display("FAIL release_grant busy=%0b grant=%0d exp busy=1 grant=0", o_busy, o_grant);
        end
    endtask

    task automatic test_round_robin();
        int g, beat, nwr;
        do_reset();
        en  = '1;
        nwr = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (k % 5 == 0) begin
                n_checks++;
                if (o_busy !== 1'b0 || o_winc !== 1'b0) begin
                    n_errors++; $display("FAIL rr_bubble k=%0d busy=%0b winc=%0b exp 0/0", k, o_busy, o_winc);
                end
            end else begin
                g    = (k / 5) % NREQ;
                beat = ((k / 5) == 4 ? 4 : 0) + (k % 5) - 1;
                n_checks++;
                if (o_busy !== 1'b1 || o_grant !== 2'(g) || o_winc !== 1'b1) begin
                    n_errors++; $display("FAIL rr_grant k=%0d busy=%0b grant=%0d winc=%0b exp grant=%0d", k, o_busy, o_grant, o_winc, g);
                end
                n_checks++;
                if (o_wdata !== 8'(16 * g + beat)) begin
                    n_errors++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, o_wdata, 8'(16 * g + beat));
                end
            end
            if (o_winc) nwr++;
        end
        n_checks++;
        if (nwr != 20) begin n_errors++; $display("FAIL rr_count got=%0d exp=20", nwr); end
    endtask

    task automatic test_early_last();
        do_reset();
        base[2] = 8'hA0;
        plen[2] = 2;
        en[2]   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k > 0) begin
                n_checks++;
                if (o_winc !== 1'b1 || o_wdata !== 8'(8'hA0 + k - 1)) begin
                    n_errors++; $display("FAIL early_beat k=%0d winc=%0b data=%h exp=%h", k, o_winc, o_wdata, 8'(8'hA0 + k - 1));
                end
            end
        end
        en = '1;
        for (int i = 0; i < NREQ; i++) plen[i] = 0;
        step();
        n_checks++;
        if (o_busy !== 1'b0 || o_winc !== 1'b0) begin
            n_errors++; $display("FAIL early_idle busy=%0b winc=%0b exp 0/0", o_busy, o_winc);
        end
        step();
        n_checks++;
        if (o_busy !== 1'b1 || o_grant !== 2'd3) begin
            n_errors++; $display("FAIL early_next_grant got=%0d exp=3", o_grant);
        end
    endtask

    task automatic test_back_pressure();
        int  nwr;
        logic exp_w;
        int  wexp;
        do_reset();
        base[1] = 8'h10;
        plen[1] = 4;
        en[1]   = 1'b1;
        nwr     = 0;
        wexp    = 0;
        for (int k = 0; k < 9; k++) begin
            drv_full = (k >= 3 && k <= 5);
            step();
            exp_w = (k == 1 || k == 2 || k == 6 || k == 7);
            n_checks++;
            if (o_winc !== exp_w) begin
                n_errors++; $display("FAIL bp_winc k=%0d got=%0b exp=%0b", k, o_winc, exp_w);
            end
            if (exp_w) begin
                n_checks++;
                if (o_wdata !== 8'(8'h10 + wexp)) begin
                    n_errors++; $display("FAIL bp_data k=%0d got=%h exp=%h", k, o_wdata, 8'(8'h10 + wexp));
                end
                wexp++;
            end
            if (k >= 3 && k <= 5) begin
                n_checks++;
                if (o_ready[1] !== 1'b0 || o_busy !== 1'b1) begin
                    n_errors++; $display("FAIL bp_stall k=%0d ready=%0b busy=%0b exp 0/1", k, o_ready[1], o_busy);
                end
            end
            if (o_winc) nwr++;
        end
        n_checks++;
        if (nwr != 4) begin n_errors++; $display("FAIL bp_count got=%0d exp=4", nwr); end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        plen[0] = 1;
        en[0]   = 1'b1;
        step();
        step();
        en[0]   = 1'b1;
        en[3]   = 1'b1;
        plen[0] = 0;
        for (int k = 2; k < 14; k++) begin
            step();
            if (k == 3 || k == 8 || k == 13) begin
                n_checks++;
                if (o_busy !== 1'b1 || o_grant !== ((k == 8) ? 2'd0 : 2'd3)) begin
                    n_errors++; $display("FAIL wrap_grant k=%0d got=%0d exp=%0d", k, o_grant, (k == 8) ? 0 : 3);
                end
            end
            if (k == 7 || k == 12) begin
                n_checks++;
                if (o_busy !== 1'b0) begin n_errors++; $display("FAIL wrap_bubble k=%0d got=%0b exp=0", k, o_busy); end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        plen[1] = 1;
        en[1]   = 1'b1;
        step();
        step();
        en = '1;
        for (int i = 0; i < NREQ; i++) plen[i] = 0;
        step();
        step();
        n_checks++;
        if (o_winc !== 1'b1 || o_grant !== 2'd2) begin
            n_errors++; $display("FAIL mid_pre winc=%0b grant=%0d exp 1/2", o_winc, o_grant);
        end
        drv_rst_n = 1'b0;
        step();
        n_checks++;
        if (o_winc !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset winc=%0b busy=%0b exp 0/0", o_winc, o_busy);
        end
        step();
        drv_rst_n = 1'b1;
        step();
        n_checks++;
        if (o_busy !== 1'b0) begin n_errors++; $display("FAIL mid_idle got=%0b exp=0", o_busy); end
        step();
        n_checks++;
        if (o_busy !== 1'b1 || o_grant !== 2'd0) begin
            n_errors++; $display("FAIL mid_rr grant=%0d exp=0", o_grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!en[i] && ($urandom % 4 == 0)) begin
                    en[i]   = 1'b1;
                    plen[i] = $urandom_range(1, 6);
                    bidx[i] = 0;
                    base[i] = 8'($urandom);
                end
                drop[i] = ($urandom % 8 == 0);
            end
            drv_full = ($urandom % 4 == 0);
            step();
            n_checks++;
            if (o_busy !== e_busy) begin n_errors++; $display("FAIL rand_busy c=%0d got=%0b exp=%0b", c, o_busy, e_busy); end
            n_checks++;
            if (o_winc !== e_winc) begin n_errors++; $display("FAIL rand_winc c=%0d got=%0b exp=%0b", c, o_winc, e_winc); end
            n_checks++;
            if (o_ready !== e_ready) begin n_errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, o_ready, e_ready); end
            if (e_busy) begin
                n_checks++;
                if (o_grant !== 2'(e_grant)) begin n_errors++; $display("FAIL rand_grant c=%0d got=%0d exp=%0d", c, o_grant, e_grant); end
            end
            if (e_winc) begin
                n_checks++;
                if (o_wdata !== e_wdata) begin n_errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, o_wdata, e_wdata); end
            end
        end
    endtask

    initial begin
        wrstn     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wfull     = 1'b0;
        m_owner   = -1;
        m_rr      = 0;
        m_taken   = 0;
        test_reset();
        test_round_robin();
        test_early_last();
        test_back_pressure();
        test_wrap_skip();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
